// File: rtl/up_counter_ctrl_pkg.sv
// Shared types and defaults for the interval-timer scheduler.
package up_counter_ctrl_pkg;

  localparam int unsigned CTRL_CW   = 20;
  localparam int unsigned CTRL_NREQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after index last_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   gnt_idx_o
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IW'((32'(last_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/up_counter_ctrl.sv
// Shares one external up_counter among NREQ requesters, one interval at a time,
// granting round-robin and pulsing done to the owner when the interval expires.
module up_counter_ctrl
  import up_counter_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = CTRL_NREQ,
  parameter int unsigned CW   = CTRL_CW
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*CW-1:0] len_i,
  output logic [NREQ-1:0]    grant_o,
  output logic [NREQ-1:0]    done_o,
  output logic               busy_o,
  output logic               cnt_sclr_o,
  input  logic [CW-1:0]      cnt_q_i
);

  localparam int unsigned IW = $clog2(NREQ);

  ctrl_state_t   state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] target_q, target_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic          busy_q, busy_d;
  logic          sclr_q, sclr_d;

  logic [NREQ-1:0] arb_req, arb_gnt;
  logic [IW-1:0]   arb_idx;

  // Arbitration runs in IDLE and in DONE; in DONE the just-served owner is
  // masked so it can only re-request through the following IDLE cycle.
  always_comb begin
    arb_req = '0;
    if (state_q == IDLE) begin
      arb_req = req_i;
    end else if (state_q == DONE) begin
      arb_req = req_i & ~(NREQ'(1) << owner_q);
    end
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i     (arb_req),
    .last_i    (last_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= IW'(NREQ - 1);
      target_q <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      sclr_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      target_q <= target_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      sclr_q   <= sclr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    target_d = target_q;
    case (state_q)
      IDLE, DONE: begin
        if (|arb_gnt) begin
          state_d  = CLEAR;
          owner_d  = arb_idx;
          target_d = len_i[32'(arb_idx) * CW +: CW];
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (!req_i[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        // Abort wins over a same-cycle match.
        if (!req_i[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (cnt_q_i == target_q) begin
          state_d = DONE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    grant_d = ((state_d == CLEAR) || (state_d == COUNT)) ? (NREQ'(1) << owner_d) : '0;
    done_d  = (state_d == DONE) ? (NREQ'(1) << owner_d) : '0;
    busy_d  = (state_d == CLEAR) || (state_d == COUNT);
    sclr_d  = (state_d != COUNT);
  end

  assign grant_o    = grant_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;
  assign cnt_sclr_o = sclr_q;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Bench for up_counter_ctrl: behavioural counter, interval-level reference
// model, directed scenarios and a randomized requester mix.
module tb_up_counter_ctrl;

  localparam int NREQ = 4;
  localparam int CW   = 20;

  logic               clk, rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]    grant, done;
  logic               busy, cnt_sclr;
  logic [CW-1:0]      cnt_q;
  logic               jump;
  logic [CW-1:0]      jump_val;

  int total, bad, cyc;

  // Reference model: current owner, its grant cycle and expected done cycle.
  int m_own, m_last, m_g, m_dl;
  bit m_pdone;
  logic [NREQ-1:0] e_grant, e_done;
  logic            e_busy, e_sclr;

  up_counter_ctrl #(.NREQ(NREQ), .CW(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .len_i      (len),
    .grant_o    (grant),
    .done_o     (done),
    .busy_o     (busy),
    .cnt_sclr_o (cnt_sclr),
    .cnt_q_i    (cnt_q)
  );

  // External up_counter; jump lets a long interval be fast-forwarded.
  always_ff @(posedge clk) begin
    if (cnt_sclr)  cnt_q <= '0;
    else if (jump) cnt_q <= jump_val;
    else           cnt_q <= cnt_q + 1'b1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge();
    logic [NREQ-1:0] mask;
    int n, i;
    n = cyc + 1;
    e_done = '0;
    if (rst) begin
      m_own = -1; m_last = NREQ - 1; m_pdone = 0;
    end else if (m_own >= 0) begin
      if (!req[m_own]) begin
        m_last = m_own; m_own = -1; m_pdone = 0;
      end else if (n == m_dl) begin
        e_done[m_own] = 1'b1; m_last = m_own; m_own = -1; m_pdone = 1;
      end
    end else begin
      mask = req;
      if (m_pdone) mask[m_last] = 1'b0;
      m_pdone = 0;
      for (int k = 1; k <= NREQ; k++) begin
        i = (m_last + k) % NREQ;
        if (m_own < 0 && mask[i]) begin
          m_own = i;
          m_g   = n;
          m_dl  = n + int'(len[i*CW +: CW]) + 2;
        end
      end
    end
    e_grant = (m_own >= 0) ? (NREQ'(1) << m_own) : '0;
    e_busy  = (m_own >= 0);
    e_sclr  = !((m_own >= 0) && (n > m_g));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; jump = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1;
    for (int i = 0; i < NREQ; i++) len[i*CW +: CW] = CW'(3);
    step(); step();
    total++;
    if ({grant, done, busy, cnt_sclr} !== {4'b0000, 4'b0000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_outputs got %b want %b", {grant, done, busy, cnt_sclr}, 10'b0000000001);
    end
    rst = 1'b0;
    step();
    total++;
    if (grant !== 4'b0001) begin
      bad++; $display("FAIL reset_first_grant got %b want 0001", grant);
    end
    total++;
    if ({grant, done, busy, cnt_sclr} !== {e_grant, e_done, e_busy, e_sclr}) begin
      bad++; $display("FAIL reset_model got %b want %b", {grant, done, busy, cnt_sclr}, {e_grant, e_done, e_busy, e_sclr});
    end
    req = '0;
    repeat (3) step();
    total++;
    if (grant !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin
      bad++; $display("FAIL reset_abort_idle got g=%b b=%b d=%b want 0000/0/0000", grant, busy, done);
    end
  endtask

  task automatic test_single();
    int t0, k;
    do_reset();
    len[2*CW +: CW] = CW'(5); req = 4'b0100; t0 = cyc;
    for (int s = 0; s < 10; s++) begin
      step(); k = cyc - t0;
      total++;
      if ({grant, done, busy, cnt_sclr} !== {e_grant, e_done, e_busy, e_sclr}) begin
        bad++; $display("FAIL single_model k=%0d got %b want %b", k, {grant, done, busy, cnt_sclr}, {e_grant, e_done, e_busy, e_sclr});
      end
      total++;
      if (done !== ((k == 8) ? 4'b0100 : 4'b0000)) begin
        bad++; $display("FAIL single_done k=%0d got %b", k, done);
      end
      if (k == 1) begin
        total++;
        if (grant !== 4'b0100 || cnt_sclr !== 1'b1) begin
          bad++; $display("FAIL single_grant got g=%b s=%b want 0100/1", grant, cnt_sclr);
        end
      end
      if (k >= 2 && k <= 7) begin
        total++;
        if (cnt_q !== CW'(k - 2) || cnt_sclr !== 1'b0) begin
          bad++; $display("FAIL single_cnt k=%0d got q=%0d s=%b want q=%0d s=0", k, cnt_q, cnt_sclr, k - 2);
        end
      end
      if (k == 8) req = 4'b0000;
    end
  endtask

  task automatic test_round_robin();
    int t0, n, r;
    logic [NREQ-1:0] eg, ed;
    do_reset();
    rst = 1'b1; req = 4'b1111;
    for (int i = 0; i < NREQ; i++) len[i*CW +: CW] = CW'(2);
    step();
    rst = 1'b0; t0 = cyc;
    for (int k = 1; k <= 25; k++) begin
      step();
      n = (k - 1) / 5; r = (k - 1) % 5;
      eg = (r < 4)  ? (NREQ'(1) << (n % 4)) : '0;
      ed = (r == 4) ? (NREQ'(1) << (n % 4)) : '0;
      total++;
      if (grant !== eg || done !== ed) begin
        bad++; $display("FAIL rr_order k=%0d got g=%b d=%b want g=%b d=%b", cyc - t0, grant, done, eg, ed);
      end
      total++;
      if ({grant, done, busy, cnt_sclr} !== {e_grant, e_done, e_busy, e_sclr}) begin
        bad++; $display("FAIL rr_model k=%0d got %b want %b", k, {grant, done, busy, cnt_sclr}, {e_grant, e_done, e_busy, e_sclr});
      end
    end
    req = '0;
    repeat (3) step();
  endtask

  task automatic test_abort();
    int t0, k;
    do_reset();
    len[1*CW +: CW] = CW'(100); len[3*CW +: CW] = CW'(7);
    req = 4'b1010; t0 = cyc;
    for (int s = 0; s < 24; s++) begin
      step(); k = cyc - t0;
      total++;
      if ({grant, done, busy, cnt_sclr} !== {e_grant, e_done, e_busy, e_sclr}) begin
        bad++; $display("FAIL abort_model k=%0d got %b want %b", k, {grant, done, busy, cnt_sclr}, {e_grant, e_done, e_busy, e_sclr});
      end
      total++;
      if (done !== ((k == 22) ? 4'b1000 : 4'b0000)) begin
        bad++; $display("FAIL abort_done k=%0d got %b", k, done);
      end
      if (k == 12 || k == 13) begin
        total++;
        if (grant !== ((k == 12) ? 4'b0000 : 4'b1000)) begin
          bad++; $display("FAIL abort_regrant k=%0d got %b", k, grant);
        end
      end
      if (k == 11) req[1] = 1'b0;
      if (k == 22) req[3] = 1'b0;
    end
  endtask

  task automatic test_len_zero();
    int t0, k;
    do_reset();
    len[0 +: CW] = '0; req = 4'b0001; t0 = cyc;
    for (int s = 0; s < 6; s++) begin
      step(); k = cyc - t0;
      total++;
      if (done !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL len0_done k=%0d got %b", k, done);
      end
      total++;
      if ({grant, done, busy, cnt_sclr} !== {e_grant, e_done, e_busy, e_sclr}) begin
        bad++; $display("FAIL len0_model k=%0d got %b want %b", k, {grant, done, busy, cnt_sclr}, {e_grant, e_done, e_busy, e_sclr});
      end
      if (k == 3) req = '0;
    end
  endtask

  // Full-scale interval: the counter is fast-forwarded from 49 to FFFEB, so the
  // unskipped done cycle 2^20+2 lands at k=72.
  task automatic test_len_max();
    int t0, k;
    do_reset();
    len[2*CW +: CW] = 20'hFFFFF; req = 4'b0100; t0 = cyc;
    for (int s = 0; s < 75; s++) begin
      step(); k = cyc - t0;
      jump = 1'b0;
      total++;
      if (done !== ((k == 72) ? 4'b0100 : 4'b0000)) begin
        bad++; $display("FAIL lenmax_done k=%0d got %b q=%h", k, done, cnt_q);
      end
      total++;
      if ({grant, done, busy, cnt_sclr} !== {e_grant, e_done, e_busy, e_sclr}) begin
        bad++; $display("FAIL lenmax_model k=%0d got %b want %b", k, {grant, done, busy, cnt_sclr}, {e_grant, e_done, e_busy, e_sclr});
      end
      if (k == 71) begin
        total++;
        if (cnt_q !== 20'hFFFFF) begin
          bad++; $display("FAIL lenmax_cnt got %h want fffff", cnt_q);
        end
      end
      if (k == 50) begin
        jump = 1'b1; jump_val = 20'hFFFEB;
        m_dl = m_dl - (32'hFFFEB - 49);
      end
      if (k == 72) req = '0;
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    do_reset();
    len[0 +: CW] = CW'(50); req = 4'b0001; t0 = cyc;
    repeat (10) step();
    rst = 1'b1;
    step();
    total++;
    if ({grant, done, busy, cnt_sclr} !== {4'b0000, 4'b0000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_mid got %b want %b", {grant, done, busy, cnt_sclr}, 10'b0000000001);
    end
    rst = 1'b0; req = '0;
    step();
    total++;
    if ({grant, done, busy, cnt_sclr} !== {e_grant, e_done, e_busy, e_sclr}) begin
      bad++; $display("FAIL reset_mid_model got %b want %b", {grant, done, busy, cnt_sclr}, {e_grant, e_done, e_busy, e_sclr});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int s = 0; s < 800; s++) begin
      step();
      total++;
      if ({grant, done, busy, cnt_sclr} !== {e_grant, e_done, e_busy, e_sclr}) begin
        bad++; $display("FAIL random_model cyc=%0d got %b want %b", cyc, {grant, done, busy, cnt_sclr}, {e_grant, e_done, e_busy, e_sclr});
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) begin
            len[i*CW +: CW] = CW'($urandom_range(12));
            req[i] = 1'b1;
          end
        end else if (done[i]) begin
          if ($urandom_range(2) != 0) req[i] = 1'b0;
        end else if ($urandom_range(39) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    repeat (3) step();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    m_own = -1; m_last = NREQ - 1; m_g = 0; m_dl = 0; m_pdone = 0;
    rst = 1'b1; req = '0; len = '0; jump = 1'b0; jump_val = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_len_zero();
    test_len_max();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
